// File: rtl/inst_fetch_pkg.sv
// Shared CPU package: fetch FSM encodings, the NOP word, and the opcode
// constants used by the control decoder.
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Jump target keeps the top nibble of the delay-slot address.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                               input logic [25:0] idx);
      return {pc4[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_data);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_data);
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register with write enable and asynchronous active-low reset.
module pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)  q <= RESET_PC;
      else if (we) q <= d;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD FSM with a one-entry skid buffer
// that absorbs a word returned while decode is stalled.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         stall_i,
   input  logic         branch_i,
   input  logic [31:0]  branch_addr_i,
   input  logic         jump_i,
   input  logic [25:0]  jump_idx_i,
   output logic         imem_req_o,
   output logic [31:0]  imem_addr_o,
   input  logic         imem_ack_i,
   input  logic [31:0]  imem_data_i,
   output logic [31:0]  inst_o,
   output logic [5:0]   op_o,
   output logic [31:0]  pc4_o,
   output logic         inst_valid_o,
   output fetch_state_e state_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic [31:0]  skid_q, skid_d;
   logic [31:0]  pc_q, pc_d, pc_plus4, target;
   logic         pc_we, redirect;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (pc_we),
      .d     (pc_d),
      .q     (pc_q)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         inst_q  <= NOP_WORD;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         skid_q  <= NOP_WORD;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         skid_q  <= skid_d;
      end
   end

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = branch_i | jump_i;
   assign target   = branch_i ? branch_addr_i : jump_target(pc4_q, jump_idx_i);

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      skid_d  = skid_q;
      pc_we   = 1'b0;
      pc_d    = pc_q;
      // A redirect outranks stall and ack: flush output, skid and any returned word.
      if (state_q != ST_IDLE && redirect) begin
         pc_we   = 1'b1;
         pc_d    = target;
         inst_d  = NOP_WORD;
         valid_d = 1'b0;
         skid_d  = NOP_WORD;
         state_d = ST_FETCH;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pc_we = 1'b1;
               pc_d  = RESET_PC;
               if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (!stall_i) begin
                  if (imem_ack_i) begin
                     inst_d  = imem_data_i;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                     pc_we   = 1'b1;
                     pc_d    = pc_plus4;
                  end else begin
                     inst_d  = NOP_WORD;
                     valid_d = 1'b0;
                  end
               end else if (imem_ack_i) begin
                  skid_d  = imem_data_i;
                  pc_we   = 1'b1;
                  pc_d    = pc_plus4;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               // PC already advanced past the buffered word, so it is that word's pc4.
               if (!stall_i) begin
                  inst_d  = skid_q;
                  pc4_d   = pc_q;
                  valid_d = 1'b1;
                  skid_d  = NOP_WORD;
                  state_d = ST_FETCH;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign imem_req_o   = (state_q == ST_FETCH);
   assign imem_addr_o  = pc_q;
   assign inst_o       = inst_q;
   assign op_o         = inst_q[31:26];
   assign pc4_o        = pc4_q;
   assign inst_valid_o = valid_q;
   assign state_o      = state_q;

endmodule
